// File: rtl/cpu_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cpu_step_ctrl
// Purpose  : Board-input conditioning and execution control for the
//            multi-cycle CPU. Each raw button is synchronised and debounced
//            into a clean level and a rising-edge pulse. A small FSM turns
//            the mode switches and the go/abort buttons into the registered
//            CPU clock-enable.
//
// Ports    : clk          system clock, rising edge
//            rst_n        asynchronous assert, active-low reset
//            btn_raw_i    raw asynchronous buttons (ch0 = go, ch1 = abort)
//            mode_i       00 HALT, 01 RUN, 10 STEP, 11 BURST
//            burst_len_i  burst length, sampled on the go pulse
//            btn_level_o  debounced button levels
//            btn_pulse_o  one-cycle pulse, the cycle after a level rises
//            cpu_en_o     registered CPU clock-enable
//            busy_o       high while a burst is in progress
//            step_cnt_o   number of cycles with cpu_en_o = 1 (wraps)
//
// Options  : CPU_STEP_CNT_EN - when defined, the executed-cycle counter is
//            built; otherwise step_cnt_o is tied to zero.
//
// Revision : 1.0 - initial release
// ============================================================================
module cpu_step_ctrl #(
    parameter int NBTN       = 5,
    parameter int DEB_CYCLES = 16,
    parameter int BURST_W    = 8,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NBTN-1:0]    btn_raw_i,
    input  logic [1:0]         mode_i,
    input  logic [BURST_W-1:0] burst_len_i,
    output logic [NBTN-1:0]    btn_level_o,
    output logic [NBTN-1:0]    btn_pulse_o,
    output logic               cpu_en_o,
    output logic               busy_o,
    output logic [CNT_W-1:0]   step_cnt_o
);

    localparam int DW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DW-1:0]      c_DEB_MAX    = DW'(DEB_CYCLES - 1);
    localparam logic [BURST_W-1:0] c_REM_LAST   = BURST_W'(1);
    localparam logic [1:0]         c_MODE_RUN   = 2'b01;
    localparam logic [1:0]         c_MODE_STEP  = 2'b10;
    localparam logic [1:0]         c_MODE_BURST = 2'b11;

    // ------------------------------------------------------------------
    // Per-channel synchroniser, debouncer and rising-edge pulse
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NBTN; gi++) begin : g_chan
        logic          sync1_q;
        logic          sync2_q;
        logic          level_q;
        logic          level_prev_q;
        logic          pulse_q;
        logic [DW-1:0] cnt_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1_q      <= 1'b0;
                sync2_q      <= 1'b0;
                level_q      <= 1'b0;
                level_prev_q <= 1'b0;
                pulse_q      <= 1'b0;
                cnt_q        <= '0;
            end else begin
                sync1_q      <= btn_raw_i[gi];
                sync2_q      <= sync1_q;
                level_prev_q <= level_q;
                // Pulse lands one cycle after the level rises.
                pulse_q      <= level_q & ~level_prev_q;
                if (sync2_q == level_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == c_DEB_MAX) begin
                    // DEB_CYCLES consecutive disagreeing samples: accept.
                    cnt_q   <= '0;
                    level_q <= ~level_q;
                end else begin
                    cnt_q <= cnt_q + DW'(1);
                end
            end
        end

        assign btn_level_o[gi] = level_q;
        assign btn_pulse_o[gi] = pulse_q;
    end

    logic w_go;
    logic w_abort;
    assign w_go    = btn_pulse_o[0];
    assign w_abort = btn_pulse_o[1];

    // ------------------------------------------------------------------
    // Execution-control FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_BURST = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [BURST_W-1:0] rem_q, rem_d;     // enabled cycles left, incl. current
    logic               cpu_en_q, cpu_en_d;

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        cpu_en_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Abort outranks everything, so it also swallows a
                // coincident go or a pending RUN entry for one cycle.
                if (!w_abort) begin
                    if (mode_i == c_MODE_RUN) begin
                        state_d  = S_RUN;
                        cpu_en_d = 1'b1;
                    end else if (w_go && mode_i == c_MODE_STEP) begin
                        cpu_en_d = 1'b1;
                    end else if (w_go && mode_i == c_MODE_BURST &&
                                 burst_len_i != '0) begin
                        state_d  = S_BURST;
                        rem_d    = burst_len_i;
                        cpu_en_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (w_abort || mode_i != c_MODE_RUN) begin
                    state_d = S_IDLE;
                end else begin
                    cpu_en_d = 1'b1;
                end
            end
            S_BURST: begin
                // go is deliberately ignored here: no reload, no extension.
                if (w_abort || mode_i != c_MODE_BURST || rem_q == c_REM_LAST) begin
                    state_d = S_IDLE;
                    rem_d   = '0;
                end else begin
                    rem_d    = rem_q - c_REM_LAST;
                    cpu_en_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                rem_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            rem_q    <= '0;
            cpu_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            cpu_en_q <= cpu_en_d;
        end
    end

    assign cpu_en_o = cpu_en_q;
    // state_q is BURST exactly during the cycles the burst enables the CPU.
    assign busy_o   = (state_q == S_BURST);

    // ------------------------------------------------------------------
    // Executed-cycle counter
    // ------------------------------------------------------------------
`ifdef CPU_STEP_CNT_EN
    logic [CNT_W-1:0] step_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_cnt_q <= '0;
        end else if (cpu_en_q) begin
            step_cnt_q <= step_cnt_q + CNT_W'(1);
        end
    end

    assign step_cnt_o = step_cnt_q;
`else
    assign step_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpu_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_step_ctrl
// Purpose  : Directed self-checking bench for cpu_step_ctrl with
//            DEB_CYCLES = 4 and CNT_W = 4. Step-counter expectations follow
//            CPU_STEP_CNT_EN (zero when the counter is not built).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_step_ctrl;

    localparam int NBTN = 5;
    localparam int DEB  = 4;
    localparam int BW   = 8;
    localparam int CW   = 4;
`ifdef CPU_STEP_CNT_EN
    localparam logic [31:0] c_CNT_MASK = 32'h0000_000F;
`else
    localparam logic [31:0] c_CNT_MASK = 32'h0000_0000;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NBTN-1:0] btn_raw;
    logic [1:0]      mode;
    logic [BW-1:0]   burst_len;
    logic [NBTN-1:0] btn_level;
    logic [NBTN-1:0] btn_pulse;
    logic            cpu_en;
    logic            busy;
    logic [CW-1:0]   step_cnt;

    cpu_step_ctrl #(
        .NBTN(NBTN), .DEB_CYCLES(DEB), .BURST_W(BW), .CNT_W(CW)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_raw_i  (btn_raw),
        .mode_i     (mode),
        .burst_len_i(burst_len),
        .btn_level_o(btn_level),
        .btn_pulse_o(btn_pulse),
        .cpu_en_o   (cpu_en),
        .busy_o     (busy),
        .step_cnt_o (step_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Observation counters, updated once per cycle at the falling edge.
    int cyc, n_en, n_adj, n_bmis, n_p0, n_p1, en_first, en_last, p0_first, p0_last;
    logic prev_en;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        cyc = 0; n_en = 0; n_adj = 0; n_bmis = 0; n_p0 = 0; n_p1 = 0;
        en_first = -1; en_last = -1; p0_first = -1; p0_last = -1;
        prev_en = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (cpu_en) begin
            n_en++;
            if (prev_en) n_adj++;
            if (en_first < 0) en_first = cyc;
            en_last = cyc;
        end
        prev_en = cpu_en;
        if (busy !== cpu_en) n_bmis++;
        if (btn_pulse[0]) begin
            n_p0++;
            if (p0_first < 0) p0_first = cyc;
            p0_last = cyc;
        end
        if (btn_pulse[1]) n_p1++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        clr();
    endtask

    task automatic press(input int ch, input int hold);
        btn_raw[ch] = 1'b1;
        repeat (hold) tick();
        btn_raw[ch] = 1'b0;
        repeat (10) tick();
    endtask

    function automatic logic [31:0] exp_cnt(input int n);
        return 32'(n) & c_CNT_MASK;
    endfunction

    initial begin
        int k;
        clr();
        rst_n     = 1'b0;
        btn_raw   = 5'h1F;
        mode      = 2'b00;
        burst_len = 8'd0;

        // ---------------- reset and release ----------------
        repeat (3) tick();
        check("rst_level",  32'(btn_level), 32'h0);
        check("rst_pulse",  32'(btn_pulse), 32'h0);
        check("rst_cpu_en", 32'(cpu_en),    32'h0);
        check("rst_busy",   32'(busy),      32'h0);
        check("rst_cnt",    32'(step_cnt),  32'h0);
        rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 5) check("lvl_before", 32'(btn_level), 32'h00);
            if (i == 6) check("lvl_after",  32'(btn_level), 32'h1F);
            if (i == 6) check("pulse_early", 32'(btn_pulse), 32'h00);
            if (i == 7) check("pulse_on",   32'(btn_pulse), 32'h1F);
            if (i == 8) check("pulse_off",  32'(btn_pulse), 32'h00);
        end
        clr();
        btn_raw = 5'h00;
        repeat (12) tick();
        check("lvl_fall",      32'(btn_level), 32'h00);
        check("no_fall_pulse", 32'(n_p0 + n_p1), 32'h0);

        // ---------------- bounce on ch0 ----------------
        clr();
        for (int i = 0; i < 10; i++) begin
            btn_raw[0] = (i % 2 == 0);
            tick();
            if (btn_level[0]) n_adj++;
            tick();
            if (btn_level[0]) n_adj++;
        end
        check("bounce_no_level", 32'(n_adj), 32'h0);
        btn_raw[0] = 1'b1;
        k = 0;
        while (!btn_level[0] && k < 20) begin
            tick();
            k++;
        end
        check("bounce_latency", 32'(k), 32'd6);
        repeat (4) tick();
        check("bounce_pulses", 32'(n_p0), 32'd1);
        check("halt_no_en",    32'(n_en), 32'd0);
        btn_raw[0] = 1'b0;
        repeat (10) tick();

        // ---------------- STEP ----------------
        do_reset();
        mode = 2'b10;
        repeat (3) press(0, 8);
        check("step_en",    32'(n_en),  32'd3);
        check("step_adj",   32'(n_adj), 32'd0);
        check("step_go",    32'(n_p0),  32'd3);
        check("step_cnt",   32'(step_cnt), exp_cnt(3));

        // ---------------- BURST of 5 ----------------
        do_reset();
        mode      = 2'b11;
        burst_len = 8'd5;
        press(0, 8);
        repeat (5) tick();
        check("b5_en",     32'(n_en), 32'd5);
        check("b5_consec", 32'(en_last - en_first + 1), 32'd5);
        check("b5_first",  32'(en_first - p0_first), 32'd1);
        check("b5_busy",   32'(n_bmis), 32'd0);
        check("b5_cnt",    32'(step_cnt), exp_cnt(5));

        // ---------------- BURST of 20, second go inside ----------------
        do_reset();
        burst_len = 8'd20;
        btn_raw[0] = 1'b1; repeat (8) tick();
        btn_raw[0] = 1'b0; repeat (6) tick();
        btn_raw[0] = 1'b1; repeat (8) tick();
        btn_raw[0] = 1'b0; repeat (20) tick();
        check("b20_gos",    32'(n_p0), 32'd2);
        check("b20_inside", 32'(p0_last > en_first && p0_last < en_last), 32'd1);
        check("b20_en",     32'(n_en), 32'd20);
        check("b20_consec", 32'(en_last - en_first + 1), 32'd20);
        check("b20_busy",   32'(n_bmis), 32'd0);
        check("b20_cnt",    32'(step_cnt), exp_cnt(20));

        // ---------------- abort a long burst ----------------
        do_reset();
        burst_len  = 8'd200;
        btn_raw[0] = 1'b1;
        k = 0;
        while (n_en < 10 && k < 40) begin
            tick();
            k++;
        end
        check("ab_started", 32'(n_en), 32'd10);
        btn_raw[0] = 1'b0;
        btn_raw[1] = 1'b1;
        k = 0;
        while (!btn_pulse[1] && k < 30) begin
            tick();
            k++;
        end
        check("ab_pulse_seen", 32'(btn_pulse[1]), 32'h1);
        check("ab_en_in_pulse", 32'(cpu_en), 32'h1);
        tick();
        check("ab_en_off",   32'(cpu_en), 32'h0);
        check("ab_busy_off", 32'(busy),   32'h0);
        repeat (5) tick();
        check("ab_total", 32'(n_en), 32'd17);
        btn_raw[1] = 1'b0;
        repeat (10) tick();

        // burst_len = 0 is a no-op
        burst_len = 8'd0;
        clr();
        press(0, 8);
        check("b0_go", 32'(n_p0), 32'd1);
        check("b0_en", 32'(n_en), 32'd0);

        // ---------------- reset mid-burst ----------------
        do_reset();
        burst_len = 8'd200;
        press(0, 8);
        check("rb_running", 32'(cpu_en), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("rb_en_async",   32'(cpu_en), 32'h0);
        check("rb_busy_async", 32'(busy),   32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        clr();
        repeat (10) tick();
        check("rb_no_resume", 32'(n_en), 32'd0);

        // ---------------- RUN with counter wrap ----------------
        do_reset();
        mode = 2'b01;
        k = 0;
        while (n_en < 20 && k < 40) begin
            tick();
            k++;
        end
        check("run_consec", 32'(en_last - en_first + 1), 32'd20);
        mode = 2'b00;
        tick();
        check("run_stop", 32'(cpu_en), 32'h0);
        check("run_wrap", 32'(step_cnt), exp_cnt(20));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_step_ctrl.md
Name: cpu_step_ctrl

Overview:
Board-input conditioning and execution-control block for the multi-cycle CPU top.
- Synchronises and debounces NBTN raw buttons, producing clean levels and rising-edge pulses.
- Generates the CPU clock-enable `cpu_en` in four modes: halt, free-run, single-step and burst-of-N.
- Sits between the board pins (sw/btn) and the CPU core, so benches and the board can step the multi-cycle datapath deterministically.

Parameters:
NBTN, 5, number of button channels (≥2; ch0 = step/go, ch1 = abort)
DEB_CYCLES, 16, consecutive stable cycles required to accept a new button level (≥2)
BURST_W, 8, width of the burst length input
CNT_W, 16, width of the executed-cycle counter

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  asynchronous, active-low reset
btn_raw  in  NBTN  raw, bouncy, asynchronous button inputs
mode  in  2  00 HALT, 01 RUN, 10 STEP, 11 BURST (quasi-static, from sw[1:0])
burst_len  in  BURST_W  cycles per burst, sampled on the go pulse
btn_level  out  NBTN  debounced button levels
btn_pulse  out  NBTN  one-cycle pulse on each debounced rising edge
cpu_en  out  1  CPU clock-enable, registered
busy  out  1  high while a burst is in progress
step_cnt  out  CNT_W  count of cycles with cpu_en=1

Behaviour:
- Reset (async assert, sync release): sync flops, debounce counters, btn_level, btn_pulse, cpu_en, busy and step_cnt all 0; FSM goes to IDLE.
- Synchroniser: two flops per channel. `s` is the second-stage output.
- Debounce, per channel:
  - Counter clears whenever s == btn_level.
  - Otherwise the counter increments.
  - btn_level toggles on the cycle the counter would reach DEB_CYCLES, and the counter clears.
  - A bounce shorter than DEB_CYCLES never changes the level.
- Press-to-level latency: 2 + DEB_CYCLES cycles.
- btn_pulse[i] = 1 for exactly one cycle, the cycle after btn_level[i] rises. Falling edges produce no pulse.
- Let go = btn_pulse[0] and abort = btn_pulse[1].
- FSM states and transitions:
  - IDLE:
    - mode=01 → RUN.
    - mode=10 with go → cpu_en=1 for exactly one cycle, the cycle after go; stay in IDLE.
    - mode=11 with go and burst_len≠0 → load remaining=burst_len, go to BURST.
    - mode=11 with go and burst_len=0 → no-op.
    - mode=00 → cpu_en=0.
  - RUN: cpu_en=1 every cycle. Leave to IDLE (cpu_en=0 the next cycle) when mode≠01 or abort.
  - BURST:
    - cpu_en=1 and busy=1 each cycle; remaining decrements.
    - Exit to IDLE after exactly burst_len cpu_en cycles; first cpu_en is the cycle after go.
    - go pulses during BURST are ignored (no re-load, no extension).
    - abort, or mode changing away from 11, ends the burst: cpu_en=0 from the next cycle.
- Priority when events coincide: abort > mode change > go.
- step_cnt increments in every cycle where cpu_en=1 and wraps from all-ones to 0 silently.
- Reset mid-burst or mid-run: cpu_en drops immediately (asynchronously); no pending burst survives.

Optional Feature:
CPU_STEP_CNT_EN
- Defined: step_cnt is implemented as described above.
- Undefined: no counter is synthesised and step_cnt is tied to 0. All other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 with btn_raw=5'h1F → all outputs 0. Release → btn_level=5'h1F after 2+DEB_CYCLES cycles, btn_pulse=5'h1F for exactly one cycle.
- Bounce, DEB_CYCLES=4: toggle btn_raw[0] every 2 cycles for 20 cycles, then hold 1 → btn_level[0] rises exactly 6 cycles after the final edge; exactly one btn_pulse[0].
- STEP, mode=10: three separated presses → exactly three single-cycle cpu_en pulses; step_cnt=3.
- BURST, mode=11, burst_len=8'd5: one press → cpu_en high for 5 consecutive cycles, busy high for the same 5 cycles. A second press during the burst → still 5 cycles total; step_cnt=5.
- Abort: burst_len=8'd200, press ch1 after 10 enabled cycles → cpu_en=0 from the cycle after abort's pulse, busy=0. burst_len=0 plus go → no cpu_en.
- RUN and wrap, mode=01 with CNT_W=4: run 20 cycles → step_cnt=4 after wrap. Switch mode to 00 → cpu_en=0 the next cycle. With CPU_STEP_CNT_EN undefined, step_cnt stays 0.
